fsl_rx_packet_fifo: RTL and testbench
=====================================

FSL_RX_PACKET_FIFO -- requirements
Module: fsl_rx_packet_fifo

Interface
REQ-001 SHALL have parameter FSL_D_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO word capacity (power of 2, 2..64).
REQ-003 SHALL have port gclk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fsl_m_write  input  1  upstream write strobe.
REQ-006 SHALL have port fsl_m_data  input  FSL_D_WIDTH  upstream write data.
REQ-007 SHALL have port fsl_m_control  input  1  upstream control bit; 1 marks last word of packet.
REQ-008 SHALL have port fsl_m_full  output  1  FIFO full, back-pressure to upstream.
REQ-009 SHALL have port fsl_s_read  input  1  downstream pop strobe.
REQ-010 SHALL have port fsl_s_exists  output  1  FIFO holds at least one word.
REQ-011 SHALL have port fsl_s_data  output  FSL_D_WIDTH  head-of-FIFO data.
REQ-012 SHALL have port fsl_s_control  output  1  head-of-FIFO control bit.
REQ-013 SHALL have port pkt_done  output  1  one-cycle pulse, packet end accepted.
REQ-014 SHALL have port pkt_len  output  8  word count of last completed packet.
REQ-015 SHALL have port pkt_sum  output  16  checksum of last completed packet.
REQ-016 SHALL have port pkt_count  output  8  number of completed packets.
REQ-017 SHALL have port overflow  output  1  sticky: write attempted while full.
REQ-018 SHALL have port underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 SHALL accept a write when fsl_m_write=1 and fsl_m_full=0, storing {fsl_m_control, fsl_m_data} at the tail.
REQ-020 SHALL drive fsl_m_full=1 exactly when occupancy equals DEPTH, from registered occupancy only (no combinational path from fsl_s_read).
REQ-021 SHALL drop a write while full, leave FIFO and packet state unchanged, and set overflow, even if fsl_s_read=1 in the same cycle.
REQ-022 SHALL present the head word combinationally on fsl_s_data/fsl_s_control (first-word fall-through); fsl_s_exists = (occupancy != 0).
REQ-023 SHALL make an accepted word visible at fsl_s_exists one cycle after acceptance when the FIFO was empty.
REQ-024 SHALL pop the head when fsl_s_read=1 and fsl_s_exists=1; read while empty is ignored and sets underflow.
REQ-025 SHALL, on simultaneous accepted write and pop, keep occupancy unchanged; write and read pointers wrap modulo DEPTH.
REQ-026 SHALL drive fsl_s_data=0 and fsl_s_control=0 when empty.
REQ-027 SHALL keep a running word counter (8-bit, saturating at 255) and running sum (16-bit, wrapping, of data[15:0]) over accepted writes.
REQ-028 SHALL, on an accepted write with fsl_m_control=1, load pkt_len/pkt_sum next cycle with totals including that word, pulse pkt_done for one cycle, increment pkt_count (8-bit wrapping), and clear the running counters.
REQ-029 SHALL hold pkt_len, pkt_sum between packets; packet statistics are independent of downstream reads.
REQ-030 SHALL treat overflow/underflow as sticky until reset.

Reset
REQ-031 SHALL, while reset=1, asynchronously clear pointers, occupancy, running counters, pkt_done, pkt_len, pkt_sum, pkt_count, overflow, underflow; fsl_m_full=0, fsl_s_exists=0.
REQ-032 SHALL discard all FIFO contents and any partial packet on reset asserted mid-operation; the first packet after release starts at length 0.
REQ-033 SHALL ignore fsl_m_write and fsl_s_read while reset=1.

Verification
REQ-034 SHALL pass: write 3 words 0x11,0x22,0x33(ctrl=1), no reads -> pkt_done pulse cycle after third write, pkt_len=3, pkt_sum=0x0066, pkt_count=1, exists=1.
REQ-035 SHALL pass: 8 writes no reads -> fsl_m_full=1 after 8th; 9th write with read same cycle -> dropped, overflow=1, occupancy 7.
REQ-036 SHALL pass: read on empty FIFO -> underflow=1, exists stays 0, data=0.
REQ-037 SHALL pass: continuous write+read at occupancy 4 for 20 cycles -> occupancy stays 4, output order equals input order across pointer wrap.
REQ-038 SHALL pass: 300 words without ctrl then ctrl word of 0xFFFF -> pkt_len=255 (saturated), pkt_sum = wrapped 16-bit sum.
REQ-039 SHALL pass: reset asserted after 2 words of a packet, then 1 word ctrl=1 -> pkt_len=1, pkt_count=1, exists reflects only the post-reset word.

Source files
------------

// File: rtl/fsl_rx_packet_fifo.sv
// ---------------------------------------------------------------------------
// fsl_rx_packet_fifo
// Receive-side FSL FIFO with first-word fall-through output and per-packet
// statistics gathered on the write side.
//
// Ports
//   gclk            : single clock, rising edge
//   reset           : asynchronous, active-high reset
//   fsl_m_write     : upstream write strobe
//   fsl_m_data      : upstream write data
//   fsl_m_control   : upstream control bit, 1 marks the last word of a packet
//   fsl_m_full      : FIFO full, back-pressure to upstream
//   fsl_s_read      : downstream pop strobe
//   fsl_s_exists    : FIFO holds at least one word
//   fsl_s_data      : head-of-FIFO data (zero when empty)
//   fsl_s_control   : head-of-FIFO control bit (zero when empty)
//   pkt_done        : one-cycle pulse after a packet-end word is accepted
//   pkt_len         : word count of the last completed packet (saturates at 255)
//   pkt_sum         : 16-bit wrapping sum of data[15:0] of the last packet
//   pkt_count       : number of completed packets (wrapping)
//   overflow        : sticky, write attempted while full
//   underflow       : sticky, read attempted while empty
// ---------------------------------------------------------------------------
module fsl_rx_packet_fifo #(
  parameter int unsigned FSL_D_WIDTH = 32,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                   gclk,
  input  logic                   reset,
  input  logic                   fsl_m_write,
  input  logic [FSL_D_WIDTH-1:0] fsl_m_data,
  input  logic                   fsl_m_control,
  output logic                   fsl_m_full,
  input  logic                   fsl_s_read,
  output logic                   fsl_s_exists,
  output logic [FSL_D_WIDTH-1:0] fsl_s_data,
  output logic                   fsl_s_control,
  output logic                   pkt_done,
  output logic [7:0]             pkt_len,
  output logic [15:0]            pkt_sum,
  output logic [7:0]             pkt_count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = FSL_D_WIDTH + 1;

  // Storage: {control, data} per entry
  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          exists_q;

  logic          wr_acc;
  logic          rd_acc;
  logic [EW-1:0] head_word;

  logic [7:0]    run_len;
  logic [15:0]   run_sum;
  logic [7:0]    len_inc;
  logic [15:0]   sum_inc;
  logic [15:0]   word_lo;

  // Handshake qualification; full/exists come only from registered state
  always_comb begin
    wr_acc = fsl_m_write & ~full_q;
    rd_acc = fsl_s_read & exists_q;
  end

  // Next occupancy; a dropped write never changes the count
  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and the registered full/exists flags
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_q   <= 1'b0;
      exists_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      full_q   <= (count_nxt == CW'(DEPTH));
      exists_q <= (count_nxt != '0);
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge gclk) begin
    if (wr_acc && !reset) begin
      mem[wr_ptr] <= {fsl_m_control, fsl_m_data};
    end
  end

  // First-word fall-through head, forced to zero when empty
  always_comb begin
    head_word = mem[rd_ptr];
    if (exists_q) begin
      fsl_s_data    = head_word[FSL_D_WIDTH-1:0];
      fsl_s_control = head_word[EW-1];
    end else begin
      fsl_s_data    = '0;
      fsl_s_control = 1'b0;
    end
  end

  assign fsl_m_full   = full_q;
  assign fsl_s_exists = exists_q;

  // Running totals including the word currently being accepted
  always_comb begin
    word_lo = 16'(fsl_m_data);
    len_inc = (run_len == 8'hFF) ? 8'hFF : run_len + 8'd1;
    sum_inc = run_sum + word_lo;
  end

  // Packet statistics track accepted writes only, independent of reads
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      run_len   <= '0;
      run_sum   <= '0;
      pkt_done  <= 1'b0;
      pkt_len   <= '0;
      pkt_sum   <= '0;
      pkt_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (wr_acc) begin
        if (fsl_m_control) begin
          pkt_len   <= len_inc;
          pkt_sum   <= sum_inc;
          pkt_count <= pkt_count + 8'd1;
          pkt_done  <= 1'b1;
          run_len   <= '0;
          run_sum   <= '0;
        end else begin
          run_len <= len_inc;
          run_sum <= sum_inc;
        end
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge gclk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (fsl_m_write && full_q)    overflow  <= 1'b1;
      if (fsl_s_read && !exists_q)  underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fsl_rx_packet_fifo.sv
module tb_fsl_rx_packet_fifo;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          gclk;
  logic          reset;
  logic          fsl_m_write;
  logic [DW-1:0] fsl_m_data;
  logic          fsl_m_control;
  logic          fsl_m_full;
  logic          fsl_s_read;
  logic          fsl_s_exists;
  logic [DW-1:0] fsl_s_data;
  logic          fsl_s_control;
  logic          pkt_done;
  logic [7:0]    pkt_len;
  logic [15:0]   pkt_sum;
  logic [7:0]    pkt_count;
  logic          overflow;
  logic          underflow;

  fsl_rx_packet_fifo #(.FSL_D_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .gclk          (gclk),
    .reset         (reset),
    .fsl_m_write   (fsl_m_write),
    .fsl_m_data    (fsl_m_data),
    .fsl_m_control (fsl_m_control),
    .fsl_m_full    (fsl_m_full),
    .fsl_s_read    (fsl_s_read),
    .fsl_s_exists  (fsl_s_exists),
    .fsl_s_data    (fsl_s_data),
    .fsl_s_control (fsl_s_control),
    .pkt_done      (pkt_done),
    .pkt_len       (pkt_len),
    .pkt_sum       (pkt_sum),
    .pkt_count     (pkt_count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW:0] sbq[$];
  int          m_run_len;
  logic [15:0] m_run_sum;
  logic [7:0]  m_len;
  logic [15:0] m_sum;
  logic [7:0]  m_cnt;
  logic        m_done;
  logic        m_ovf;
  logic        m_unf;

  typedef struct {
    logic        w;
    logic        c;
    logic        r;
    logic [31:0] d;
    logic        ex;
    logic        fu;
    logic        dn;
    logic [7:0]  ln;
    logic [15:0] sm;
    logic [7:0]  ct;
    logic        uf;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    m_run_len = 0;
    m_run_sum = '0;
    m_len = '0; m_sum = '0; m_cnt = '0;
    m_done = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".exists"}, 64'(fsl_s_exists), 64'(sbq.size() != 0));
    chk({tag, ".full"},   64'(fsl_m_full),   64'(sbq.size() == DEPTH));
    chk({tag, ".done"},   64'(pkt_done),     64'(m_done));
    chk({tag, ".len"},    64'(pkt_len),      64'(m_len));
    chk({tag, ".sum"},    64'(pkt_sum),      64'(m_sum));
    chk({tag, ".count"},  64'(pkt_count),    64'(m_cnt));
    chk({tag, ".ovf"},    64'(overflow),     64'(m_ovf));
    chk({tag, ".unf"},    64'(underflow),    64'(m_unf));
    if (sbq.size() == 0)
      chk({tag, ".empty_data"}, 64'({fsl_s_control, fsl_s_data}), 64'(0));
  endtask

  // One clock cycle: drive, check head on pop, advance, update model, check
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic c, input logic r,
                     input string tag);
    bit acc_w, acc_r;
    logic [DW:0] exp_head;
    fsl_m_write = w; fsl_m_data = d; fsl_m_control = c; fsl_s_read = r;
    acc_w = w && (sbq.size() < DEPTH);
    acc_r = r && (sbq.size() > 0);
    if (acc_r) begin
      exp_head = sbq[0];
      chk({tag, ".head"}, 64'({fsl_s_control, fsl_s_data}), 64'(exp_head));
    end
    @(posedge gclk);
    #1;
    if (w && !acc_w) m_ovf = 1'b1;
    if (r && !acc_r) m_unf = 1'b1;
    if (acc_r) void'(sbq.pop_front());
    m_done = 1'b0;
    if (acc_w) begin
      sbq.push_back({c, d});
      m_run_len = (m_run_len >= 255) ? 255 : m_run_len + 1;
      m_run_sum = m_run_sum + d[15:0];
      if (c) begin
        m_len = 8'(m_run_len);
        m_sum = m_run_sum;
        m_cnt = m_cnt + 8'd1;
        m_done = 1'b1;
        m_run_len = 0;
        m_run_sum = '0;
      end
    end
    fsl_m_write = 1'b0; fsl_s_read = 1'b0; fsl_m_control = 1'b0;
    check_all(tag);
  endtask

  // Reset with write/read held high; both must be ignored
  task automatic do_reset();
    fsl_m_write = 1'b1; fsl_m_data = 32'hDEAD_BEEF; fsl_m_control = 1'b1; fsl_s_read = 1'b1;
    reset = 1'b1;
    #1;
    model_clear();
    check_all("rst_async");
    @(posedge gclk);
    #1;
    check_all("rst_held");
    reset = 1'b0;
    fsl_m_write = 1'b0; fsl_s_read = 1'b0; fsl_m_control = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] tsum;
    logic [31:0] rd;
    fsl_m_write = 1'b0; fsl_m_data = '0; fsl_m_control = 1'b0; fsl_s_read = 1'b0;
    reset = 1'b1;
    model_clear();

    // Empty-read underflow, then the three-word packet
    //          w     c     r     d         ex    fu    dn    ln     sm        ct     uf
    vt[0] = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0, 1'b1};
    vt[1] = '{1'b1, 1'b0, 1'b0, 32'h11, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0, 1'b1};
    vt[2] = '{1'b1, 1'b0, 1'b0, 32'h22, 1'b1, 1'b0, 1'b0, 8'd0, 16'h0000, 8'd0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 32'h33, 1'b1, 1'b0, 1'b1, 8'd3, 16'h0066, 8'd1, 1'b1};
    vt[4] = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 8'd3, 16'h0066, 8'd1, 1'b1};

    #12;
    do_reset();

    for (int i = 0; i < 5; i++) begin
      cyc(vt[i].w, vt[i].d, vt[i].c, vt[i].r, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_exists", i), 64'(fsl_s_exists), 64'(vt[i].ex));
      chk($sformatf("vec%0d.tbl_full", i),   64'(fsl_m_full),   64'(vt[i].fu));
      chk($sformatf("vec%0d.tbl_done", i),   64'(pkt_done),     64'(vt[i].dn));
      chk($sformatf("vec%0d.tbl_len", i),    64'(pkt_len),      64'(vt[i].ln));
      chk($sformatf("vec%0d.tbl_sum", i),    64'(pkt_sum),      64'(vt[i].sm));
      chk($sformatf("vec%0d.tbl_count", i),  64'(pkt_count),    64'(vt[i].ct));
      chk($sformatf("vec%0d.tbl_unf", i),    64'(underflow),    64'(vt[i].uf));
      if (i == 0) chk("vec0.tbl_data", 64'(fsl_s_data), 64'(0));
    end

    // Drain the packet; head order checked by the scoreboard
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, "drain3");
    chk("drain3.exists", 64'(fsl_s_exists), 64'(0));

    // Fill to full, then write+read while full
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'(32'h100 + i), 1'b0, 1'b0, "fill");
    chk("fill.full", 64'(fsl_m_full), 64'(1));
    chk("fill.ovf_clear", 64'(overflow), 64'(0));
    cyc(1'b1, 32'h0000_0999, 1'b0, 1'b1, "wr_full_rd");
    chk("wr_full_rd.ovf", 64'(overflow), 64'(1));
    chk("wr_full_rd.full", 64'(fsl_m_full), 64'(0));
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("occ7.exists%0d", i), 64'(fsl_s_exists), 64'(1));
      cyc(1'b0, '0, 1'b0, 1'b1, "occ7");
    end
    chk("occ7.empty", 64'(fsl_s_exists), 64'(0));
    chk("occ7.unf_clear", 64'(underflow), 64'(0));

    // Streaming at occupancy 4 across pointer wrap
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(32'hA00 + i), 1'b0, 1'b0, "pre4");
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, $urandom, 1'b0, 1'b1, "stream");
      chk("stream.occ", 64'(sbq.size()), 64'(4));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("post4.exists%0d", i), 64'(fsl_s_exists), 64'(1));
      cyc(1'b0, '0, 1'b0, 1'b1, "post4");
    end
    chk("post4.empty", 64'(fsl_s_exists), 64'(0));

    // Long packet: length saturates, sum wraps
    do_reset();
    tsum = '0;
    for (int i = 0; i < 300; i++) begin
      rd = $urandom;
      tsum = tsum + rd[15:0];
      cyc(1'b1, rd, 1'b0, 1'b1, "long");
    end
    tsum = tsum + 16'hFFFF;
    cyc(1'b1, 32'h0000_FFFF, 1'b1, 1'b1, "long_end");
    chk("long.len", 64'(pkt_len), 64'(255));
    chk("long.sum", 64'(pkt_sum), 64'(tsum));
    chk("long.done", 64'(pkt_done), 64'(1));
    cyc(1'b0, '0, 1'b0, 1'b0, "long_hold");
    chk("long_hold.len", 64'(pkt_len), 64'(255));
    chk("long_hold.done", 64'(pkt_done), 64'(0));

    // Reset mid-packet discards the partial packet
    do_reset();
    cyc(1'b1, 32'h0000_0005, 1'b0, 1'b0, "mid_a");
    cyc(1'b1, 32'h0000_0006, 1'b0, 1'b0, "mid_b");
    do_reset();
    cyc(1'b1, 32'h0000_0042, 1'b1, 1'b0, "after_rst");
    chk("after_rst.len", 64'(pkt_len), 64'(1));
    chk("after_rst.count", 64'(pkt_count), 64'(1));
    chk("after_rst.sum", 64'(pkt_sum), 64'(16'h0042));
    chk("after_rst.head", 64'({fsl_s_control, fsl_s_data}), 64'({1'b1, 32'h42}));
    cyc(1'b0, '0, 1'b0, 1'b1, "after_rst_pop");
    chk("after_rst_pop.exists", 64'(fsl_s_exists), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
